// File: rtl/if_id_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_id_fetch_queue
//
// Consumer side of the instruction-fetch interface. (pc, instruction) pairs
// from IF are buffered in a small circular FIFO. The head entry is presented
// to ID. IF is frozen while the queue is full. A taken branch (flush)
// squashes every buffered entry and the pair IF offers in that cycle.
//
// Handshake: an IF pair transfers on a rising edge when if_valid=1,
// if_freeze=0 and flush=0. The ID head transfers on a rising edge when
// id_valid=1, id_ready=1 and flush=0. Neither side may retract its
// valid/ready based on the other side within a cycle. No path exists from
// any input to any output inside the same cycle.
//
// Parameters:
//   BIT_NUMBER  width of pc and instruction words
//   DEPTH       number of queue entries (>=1, need not be a power of two)
//
// Ports:
//   clk             clock, rising edge
//   rst             synchronous reset, active-high
//   if_valid        IF presents a fetched pair this cycle
//   if_pc           pc+4 value from IF
//   if_instruction  fetched instruction
//   if_freeze       stall request to IF; high while the queue is full
//   id_ready        ID consumes the head entry this cycle
//   id_valid        head entry is valid
//   id_pc           head pc, 0 when empty
//   id_instruction  head instruction, 0 when empty
//   flush           taken branch from EXE; squash all entries
//
// Optional build macro IFID_STATS_EN adds:
//   stall_cycles    cycles with if_freeze=1 and if_valid=1 (saturating)
//   squashed_count  valid pairs discarded by flush (saturating)
// ---------------------------------------------------------------------------
module if_id_fetch_queue #(
    parameter int BIT_NUMBER = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    input  logic [BIT_NUMBER-1:0] if_pc,
    input  logic [BIT_NUMBER-1:0] if_instruction,
    output logic                  if_freeze,
    input  logic                  id_ready,
    output logic                  id_valid,
    output logic [BIT_NUMBER-1:0] id_pc,
    output logic [BIT_NUMBER-1:0] id_instruction,
    input  logic                  flush
`ifdef IFID_STATS_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           squashed_count
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [BIT_NUMBER-1:0] pc_mem_q    [DEPTH];
    logic [BIT_NUMBER-1:0] instr_mem_q [DEPTH];

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wptr_q,  wptr_d;
    logic [PW-1:0] rptr_q,  rptr_d;

    logic push;
    logic pop;

    // Freeze comes from the registered count only, so a pop while full
    // cannot let IF refill the slot in the same cycle.
    assign if_freeze = (count_q == FULL_CNT);
    assign id_valid  = (count_q != '0);

    // Empty queue shows an all-zero bubble to ID.
    assign id_pc          = id_valid ? pc_mem_q[rptr_q]    : '0;
    assign id_instruction = id_valid ? instr_mem_q[rptr_q] : '0;

    assign push = if_valid & ~if_freeze & ~flush;
    assign pop  = id_valid & id_ready  & ~flush;

    always_comb begin
        count_d = count_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (flush) begin
            count_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
        end else begin
            if (push) begin
                wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem_q[wptr_q]    <= if_pc;
            instr_mem_q[wptr_q] <= if_instruction;
        end
    end

`ifdef IFID_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] squashed_count_q;
    logic [32:0] squash_sum;

    // Entries lost on a flush: everything buffered plus the offered pair.
    assign squash_sum = {1'b0, squashed_count_q} + 33'(count_q) + 33'(if_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q   <= '0;
            squashed_count_q <= '0;
        end else begin
            if (if_freeze && if_valid && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (flush) begin
                squashed_count_q <= squash_sum[32] ? 32'hFFFF_FFFF : squash_sum[31:0];
            end
        end
    end

    assign stall_cycles   = stall_cycles_q;
    assign squashed_count = squashed_count_q;
`endif

endmodule

// File: tb/tb_if_id_fetch_queue.sv
module tb_if_id_fetch_queue;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DEPTH=2 instance ----------------
    logic        a_if_valid = 1'b0;
    logic [31:0] a_if_pc = '0;
    logic [31:0] a_if_instr = '0;
    logic        a_id_ready = 1'b0;
    logic        a_flush = 1'b0;
    logic        a_if_freeze;
    logic        a_id_valid;
    logic [31:0] a_id_pc;
    logic [31:0] a_id_instr;
`ifdef IFID_STATS_EN
    logic [31:0] a_stall;
    logic [31:0] a_squash;
`endif

    if_id_fetch_queue #(.BIT_NUMBER(32), .DEPTH(2)) u_d2 (
        .clk            (clk),
        .rst            (rst),
        .if_valid       (a_if_valid),
        .if_pc          (a_if_pc),
        .if_instruction (a_if_instr),
        .if_freeze      (a_if_freeze),
        .id_ready       (a_id_ready),
        .id_valid       (a_id_valid),
        .id_pc          (a_id_pc),
        .id_instruction (a_id_instr),
        .flush          (a_flush)
`ifdef IFID_STATS_EN
        ,
        .stall_cycles   (a_stall),
        .squashed_count (a_squash)
`endif
    );

    // ---------------- DEPTH=3 instance ----------------
    logic        b_if_valid = 1'b0;
    logic [31:0] b_if_pc = '0;
    logic [31:0] b_if_instr = '0;
    logic        b_id_ready = 1'b0;
    logic        b_flush = 1'b0;
    logic        b_if_freeze;
    logic        b_id_valid;
    logic [31:0] b_id_pc;
    logic [31:0] b_id_instr;
`ifdef IFID_STATS_EN
    logic [31:0] b_stall;
    logic [31:0] b_squash;
`endif

    if_id_fetch_queue #(.BIT_NUMBER(32), .DEPTH(3)) u_d3 (
        .clk            (clk),
        .rst            (rst),
        .if_valid       (b_if_valid),
        .if_pc          (b_if_pc),
        .if_instruction (b_if_instr),
        .if_freeze      (b_if_freeze),
        .id_ready       (b_id_ready),
        .id_valid       (b_id_valid),
        .id_pc          (b_id_pc),
        .id_instruction (b_id_instr),
        .flush          (b_flush)
`ifdef IFID_STATS_EN
        ,
        .stall_cycles   (b_stall),
        .squashed_count (b_squash)
`endif
    );

    // ---------------- scoreboard / counters ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        flush;
        logic        if_valid;
        logic        id_ready;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_freeze;
        logic [31:0] e_stall;
        logic [31:0] e_squash;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic r, input logic f, input logic v, input logic rdy,
                                input logic [31:0] pc, input logic [31:0] ins,
                                input logic ev, input logic [31:0] epc, input logic [31:0] eins,
                                input logic efz, input logic [31:0] est, input logic [31:0] esq);
        vec_t t;
        t.rst = r; t.flush = f; t.if_valid = v; t.id_ready = rdy;
        t.pc = pc; t.instr = ins;
        t.e_valid = ev; t.e_pc = epc; t.e_instr = eins; t.e_freeze = efz;
        t.e_stall = est; t.e_squash = esq;
        return t;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_vec(input int i);
        @(negedge clk);
        rst        = vecs[i].rst;
        a_flush    = vecs[i].flush;
        a_if_valid = vecs[i].if_valid;
        a_id_ready = vecs[i].id_ready;
        a_if_pc    = vecs[i].pc;
        a_if_instr = vecs[i].instr;
        @(posedge clk);
        #1;
        check($sformatf("v%0d id_valid", i), 32'(a_id_valid), 32'(vecs[i].e_valid));
        check($sformatf("v%0d id_pc", i), a_id_pc, vecs[i].e_pc);
        check($sformatf("v%0d id_instruction", i), a_id_instr, vecs[i].e_instr);
        check($sformatf("v%0d if_freeze", i), 32'(a_if_freeze), 32'(vecs[i].e_freeze));
`ifdef IFID_STATS_EN
        check($sformatf("v%0d stall_cycles", i), a_stall, vecs[i].e_stall);
        check($sformatf("v%0d squashed_count", i), a_squash, vecs[i].e_squash);
`endif
    endtask

    // Streams 40 sequential pcs through the DEPTH=3 queue. The first cycles
    // run with id_ready=1 (steady push+pop), the rest with a random id_ready.
    task automatic run_stream();
        logic [31:0] next_pc = 32'h4;
        int pushed = 0;
        int popped = 0;
        bit push_m;
        bit pop_m;
        for (int cyc = 0; cyc < 400 && popped < 40; cyc++) begin
            @(negedge clk);
            b_if_valid = (pushed < 40);
            b_if_pc    = next_pc;
            b_if_instr = 32'hE3A0_0000 | next_pc;
            b_id_ready = (cyc < 24) ? 1'b1 : 1'($urandom_range(0, 1));
            check("stream id_valid", 32'(b_id_valid), 32'(exp_q.size() > 0));
            check("stream if_freeze", 32'(b_if_freeze), 32'(exp_q.size() == 3));
            if (exp_q.size() > 0) begin
                check("stream id_pc", b_id_pc, exp_q[0]);
                check("stream id_instruction", b_id_instr, 32'hE3A0_0000 | exp_q[0]);
            end else begin
                check("stream empty id_pc", b_id_pc, 32'h0);
            end
            push_m = b_if_valid && (exp_q.size() < 3);
            pop_m  = (exp_q.size() > 0) && b_id_ready;
            @(posedge clk);
            if (pop_m) begin
                void'(exp_q.pop_front());
                popped++;
            end
            if (push_m) begin
                exp_q.push_back(next_pc);
                next_pc = next_pc + 32'h4;
                pushed++;
            end
        end
        check("stream drained count", 32'(popped), 32'd40);
        @(negedge clk);
        b_if_valid = 1'b0;
        b_id_ready = 1'b0;
        #1;
        check("stream final id_valid", 32'(b_id_valid), 32'd0);
    endtask

    // ---------------- test ----------------
    initial begin
        //                 rst flush v rdy pc          instr           ev  e_pc        e_instr         fz stall sq
        vecs[0]  = mk(1, 0, 0, 0, 32'h0,  32'h0,         0, 32'h0,  32'h0,         0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 32'h0,  32'h0,         0, 32'h0,  32'h0,         0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 32'h0,  32'h0,         0, 32'h0,  32'h0,         0, 0, 0);
        // single pass
        vecs[3]  = mk(0, 0, 1, 1, 32'h4,  32'hE3A01005,  1, 32'h4,  32'hE3A01005,  0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 1, 32'h0,  32'h0,         0, 32'h0,  32'h0,         0, 0, 0);
        // fill and stall
        vecs[5]  = mk(0, 0, 1, 0, 32'h4,  32'hE3A00004,  1, 32'h4,  32'hE3A00004,  0, 0, 0);
        vecs[6]  = mk(0, 0, 1, 0, 32'h8,  32'hE3A00008,  1, 32'h4,  32'hE3A00004,  1, 0, 0);
        vecs[7]  = mk(0, 0, 1, 0, 32'hC,  32'hE3A0000C,  1, 32'h4,  32'hE3A00004,  1, 1, 0);
        vecs[8]  = mk(0, 0, 1, 1, 32'hC,  32'hE3A0000C,  1, 32'h8,  32'hE3A00008,  0, 2, 0);
        vecs[9]  = mk(0, 0, 1, 1, 32'hC,  32'hE3A0000C,  1, 32'hC,  32'hE3A0000C,  0, 2, 0);
        vecs[10] = mk(0, 0, 0, 1, 32'h0,  32'h0,         0, 32'h0,  32'h0,         0, 2, 0);
        // id_ready on empty queue is ignored
        vecs[11] = mk(0, 0, 0, 1, 32'h0,  32'h0,         0, 32'h0,  32'h0,         0, 2, 0);
        vecs[12] = mk(0, 0, 1, 0, 32'h10, 32'hE3A00010,  1, 32'h10, 32'hE3A00010,  0, 2, 0);
        vecs[13] = mk(0, 0, 0, 1, 32'h0,  32'h0,         0, 32'h0,  32'h0,         0, 2, 0);
        // flush with full queue and an offered pair
        vecs[14] = mk(0, 0, 1, 0, 32'h4,  32'hE3A00004,  1, 32'h4,  32'hE3A00004,  0, 2, 0);
        vecs[15] = mk(0, 0, 1, 0, 32'h8,  32'hE3A00008,  1, 32'h4,  32'hE3A00004,  1, 2, 0);
        vecs[16] = mk(0, 1, 1, 1, 32'hC,  32'hE3A0000C,  0, 32'h0,  32'h0,         0, 3, 3);
        vecs[17] = mk(0, 0, 1, 0, 32'h40, 32'hE3A00040,  1, 32'h40, 32'hE3A00040,  0, 3, 3);
        vecs[18] = mk(0, 0, 0, 1, 32'h0,  32'h0,         0, 32'h0,  32'h0,         0, 3, 3);
        // rst + flush while full
        vecs[19] = mk(0, 0, 1, 0, 32'h4,  32'hE3A00004,  1, 32'h4,  32'hE3A00004,  0, 3, 3);
        vecs[20] = mk(0, 0, 1, 0, 32'h8,  32'hE3A00008,  1, 32'h4,  32'hE3A00004,  1, 3, 3);
        vecs[21] = mk(1, 1, 1, 1, 32'hC,  32'hE3A0000C,  0, 32'h0,  32'h0,         0, 0, 0);
        // flush on empty queue drops the offered pair
        vecs[22] = mk(0, 1, 1, 0, 32'hC,  32'hE3A0000C,  0, 32'h0,  32'h0,         0, 0, 1);
        vecs[23] = mk(0, 0, 1, 0, 32'h44, 32'hE3A00044,  1, 32'h44, 32'hE3A00044,  0, 0, 1);
        // flush beats a simultaneous push and pop
        vecs[24] = mk(0, 1, 1, 1, 32'h48, 32'hE3A00048,  0, 32'h0,  32'h0,         0, 0, 3);

        for (int i = 0; i < NV; i++) begin
            apply_vec(i);
        end

        @(negedge clk);
        a_if_valid = 1'b0;
        a_flush    = 1'b0;
        a_id_ready = 1'b0;

        run_stream();

        // reset mid-operation on the DEPTH=3 queue
        @(negedge clk);
        b_if_valid = 1'b1;
        b_if_pc    = 32'h100;
        b_if_instr = 32'hE3A00100;
        @(negedge clk);
        b_if_valid = 1'b0;
        #1;
        check("d3 pre-reset id_pc", b_id_pc, 32'h100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("d3 post-reset id_valid", 32'(b_id_valid), 32'd0);
        check("d3 post-reset id_pc", b_id_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_fetch_queue.md
Name: if_id_fetch_queue

Overview:
Consumer side of the instruction-fetch interface. It accepts (pc, instruction) pairs from the IF stage and buffers them in a small FIFO. Buffered pairs are presented to the ID stage with a valid flag. The block also generates the IF stage's freeze when it is full, and squashes wrong-path instructions on a taken branch.

Parameters:
BIT_NUMBER, 32, width of pc and instruction words
DEPTH, 2, number of queue entries (>=1, any integer; need not be a power of two)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
if_valid  input  1  IF presents a fetched pair this cycle
if_pc  input  BIT_NUMBER  pc+4 value from IF
if_instruction  input  BIT_NUMBER  fetched instruction
if_freeze  output  1  stall request to IF; high when queue full
id_ready  input  1  ID consumes head entry this cycle (low = hazard stall)
id_valid  output  1  head entry is valid
id_pc  output  BIT_NUMBER  head pc; 0 when empty
id_instruction  output  BIT_NUMBER  head instruction; 0 when empty
flush  input  1  branch_taken from EXE; squash all entries

Behaviour:
- Single clock domain.
- Reset is synchronous and active-high on rst.
- Reset values: count=0, write and read pointers=0, id_valid=0, id_pc=0, id_instruction=0, if_freeze=0. Storage contents are don't-care.
- Derived signals:
  - push = if_valid & !if_freeze & !flush
  - pop = id_valid & id_ready & !flush
- Storage and outputs:
  - Storage is registered.
  - id_* outputs are combinational from the head entry and count.
  - if_freeze = (count == DEPTH), combinational from the count register.
- Latency:
  - A pair pushed at edge N appears on id_* after edge N, i.e. visible in cycle N+1.
  - There is no combinational bypass from IF to ID.
- Push only: write at wptr, wptr advances, count+1.
- Pop only: rptr advances, count-1.
- Push and pop in the same cycle (count between 1 and DEPTH-1):
  - Both pointers advance; count is unchanged.
  - Order is preserved.
- When full:
  - if_freeze=1, so push=0.
  - A pop while full frees one slot, but if_freeze stays high for that cycle and drops the next cycle. No same-cycle refill.
- When empty:
  - id_valid=0 and id_pc=id_instruction=0 (ARM NOP-equivalent bubble).
  - id_ready is ignored.
- Pointer wrap: a pointer at DEPTH-1 advances to 0.
- Flush:
  - Effective at the next edge.
  - count=0, wptr=rptr=0.
  - The incoming IF pair in the same cycle is dropped.
  - The head is not counted as consumed, even if id_ready=1.
  - Flush takes priority over push and pop.
- rst and flush asserted together: reset result (identical state).
- Reset mid-operation: all entries are discarded; the next cycle shows id_valid=0.
- Widths:
  - count is $clog2(DEPTH+1) bits.
  - Pointers are max(1, $clog2(DEPTH)) bits.
  - No overflow is possible because push is gated by if_freeze.

Optional Feature:
IFID_STATS_EN
- Defined:
  - Adds output ports stall_cycles [31:0] and squashed_count [31:0].
  - stall_cycles increments on every cycle with if_freeze=1 and if_valid=1.
  - squashed_count adds the number of valid entries discarded on flush: count, plus 1 if if_valid was high that cycle.
  - Both counters reset to 0 on rst and saturate at 32'hFFFF_FFFF.
- Undefined: those ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then release -> id_valid=0, id_pc=0, id_instruction=0, if_freeze=0.
- Single pass: push pc=32'h4, instr=32'hE3A01005 with id_ready=1 -> next cycle id_valid=1 with those values; the following cycle id_valid=0.
- Fill and stall (DEPTH=2): id_ready=0, push 32'h4 then 32'h8 -> if_freeze=1 after the second edge; a third pair 32'hC is held off. Set id_ready=1 -> outputs 32'h4 then 32'h8 in order, and if_freeze falls one cycle after the first pop.
- Flush: queue holds 32'h4 and 32'h8, if_valid=1 with 32'hC, flush=1 -> next cycle id_valid=0, count=0. Push 32'h40 -> it appears with nothing stale ahead of it. With IFID_STATS_EN, squashed_count=3.
- Wrap and concurrency: DEPTH=3, continuous push and pop of 20 sequential pcs 32'h4 to 32'h50 -> output sequence is identical and contiguous with no drops or duplicates; pointers wrap at least 6 times.
- rst during a full queue with flush=1 -> next cycle all outputs are at reset values, and the stats counters are 0.
